// File: rtl/fpsu_ret_drain.sv
// Purpose: orders up to six FP SIMD return words per cycle into a buffer and retires up to two per cycle in order.
// Latency: a word returned at edge N is visible on out0 in cycle N+1 when the buffer was empty.
// Backpressure: per-slot rdy from the ROB; fp_stall holds off issue; returns beyond free space are dropped (ovf_err).
module fpsu_ret_drain #(
   parameter int DEPTH = 16,
   parameter int RW    = 14,
   parameter int NP    = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NP*RW-1:0]           ret_in,
   input  logic [NP-1:0]              ret_en_in,
   output logic [RW-1:0]              out0_data,
   output logic                       out0_valid,
   input  logic                       out0_rdy,
   output logic [RW-1:0]              out1_data,
   output logic                       out1_valid,
   input  logic                       out1_rdy,
   output logic                       fp_stall,
   output logic [4:0]                 fflags,
   input  logic                       fflags_clr,
   output logic                       ovf_err,
   output logic [$clog2(DEPTH):0]     cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [RW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr1;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] free;
   logic [CW-1:0] acc;
   logic [1:0]    deq;
   logic [NP-1:0] wmask;
   logic [AW-1:0] woff [NP];
   logic          drop;
   logic [4:0]    deq_flags;

   assign rd_ptr1    = rd_ptr + AW'(1);
   assign cnt        = cnt_q;
   assign out0_valid = (cnt_q != '0);
   assign out1_valid = (cnt_q >= CW'(2));
   assign out0_data  = mem[rd_ptr];
   assign out1_data  = mem[rd_ptr1];

   // In-order retire: slot 1 only counts when slot 0 also handshakes.
   always_comb begin
      deq = 2'd0;
      if (out0_valid && out0_rdy) begin
         deq = (out1_valid && out1_rdy) ? 2'd2 : 2'd1;
      end
   end

   // Compact valid ports in ascending order into the free slots; anything past free space is dropped.
   always_comb begin
      free  = CW'(DEPTH) - cnt_q + CW'(deq);
      acc   = '0;
      wmask = '0;
      drop  = 1'b0;
      for (int p = 0; p < NP; p++) begin
         woff[p] = '0;
      end
      for (int p = 0; p < NP; p++) begin
         if (ret_en_in[p]) begin
            if (acc < free) begin
               wmask[p] = 1'b1;
               woff[p]  = acc[AW-1:0];
               acc      = acc + CW'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
      cnt_nxt = cnt_q + acc - CW'(deq);
   end

   // Exception flags of the entries leaving the buffer this cycle.
   always_comb begin
      deq_flags = 5'd0;
      if (deq != 2'd0) begin
         deq_flags = deq_flags | mem[rd_ptr][4:0];
      end
      if (deq == 2'd2) begin
         deq_flags = deq_flags | mem[rd_ptr1][4:0];
      end
   end

   // Buffer storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NP; p++) begin
         if (wmask[p]) begin
            mem[wr_ptr + woff[p]] <= ret_in[p*RW +: RW];
         end
      end
   end

   // Pointers, occupancy, stall, sticky flags and overflow indication.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt_q    <= '0;
         fp_stall <= 1'b0;
         fflags   <= 5'd0;
         ovf_err  <= 1'b0;
      end else begin
         rd_ptr   <= rd_ptr + AW'(deq);
         wr_ptr   <= wr_ptr + acc[AW-1:0];
         cnt_q    <= cnt_nxt;
         fp_stall <= (cnt_nxt > CW'(DEPTH - NP));
         fflags   <= (fflags_clr ? 5'd0 : fflags) | deq_flags;
         ovf_err  <= ovf_err | drop;
      end
   end

endmodule

// File: tb/tb_fpsu_ret_drain.sv
// Purpose: self-checking bench for fpsu_ret_drain using a queue scoreboard.
// Latency: inputs change 1 time unit after each rising edge; outputs are checked at that point.
// Backpressure: rdy patterns are driven by directed phases and a random phase.
module tb_fpsu_ret_drain;

   localparam int DEPTH = 16;
   localparam int RW    = 14;
   localparam int NP    = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NP*RW-1:0]  ret_in = '0;
   logic [NP-1:0]     ret_en_in = '0;
   logic [RW-1:0]     out0_data, out1_data;
   logic              out0_valid, out1_valid;
   logic              out0_rdy = 1'b0, out1_rdy = 1'b0;
   logic              fp_stall;
   logic [4:0]        fflags;
   logic              fflags_clr = 1'b0;
   logic              ovf_err;
   logic [4:0]        cnt;

   int total = 0;
   int bad   = 0;

   logic [RW-1:0] q[$];
   logic          m_stall = 1'b0;
   logic [4:0]    m_flags = 5'd0;
   logic          m_ovf   = 1'b0;

   fpsu_ret_drain #(.DEPTH(DEPTH), .RW(RW), .NP(NP)) dut (
      .clk(clk), .rst(rst), .ret_in(ret_in), .ret_en_in(ret_en_in),
      .out0_data(out0_data), .out0_valid(out0_valid), .out0_rdy(out0_rdy),
      .out1_data(out1_data), .out1_valid(out1_valid), .out1_rdy(out1_rdy),
      .fp_stall(fp_stall), .fflags(fflags), .fflags_clr(fflags_clr),
      .ovf_err(ovf_err), .cnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic put(input int p, input logic [RW-1:0] v);
      ret_in[p*RW +: RW] = v;
   endtask

   task automatic idle();
      ret_en_in  = '0;
      out0_rdy   = 1'b0;
      out1_rdy   = 1'b0;
      fflags_clr = 1'b0;
   endtask

   // Compare DUT state with the scoreboard, advance the model, then clock once.
   task automatic tick();
      int d;
      int free;
      int n;
      logic [RW-1:0] w;
      chk("cnt", 32'(cnt), 32'(q.size()));
      chk("out0_valid", 32'(out0_valid), 32'(q.size() >= 1));
      chk("out1_valid", 32'(out1_valid), 32'(q.size() >= 2));
      if (q.size() >= 1) chk("out0_data", 32'(out0_data), 32'(q[0]));
      if (q.size() >= 2) chk("out1_data", 32'(out1_data), 32'(q[1]));
      chk("fp_stall", 32'(fp_stall), 32'(m_stall));
      chk("fflags", 32'(fflags), 32'(m_flags));
      chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
      if (!rst) begin
         q.delete();
         m_stall = 1'b0;
         m_flags = 5'd0;
         m_ovf   = 1'b0;
      end else begin
         d = 0;
         if (q.size() >= 1 && out0_rdy) d = (q.size() >= 2 && out1_rdy) ? 2 : 1;
         free = DEPTH - q.size() + d;
         if (fflags_clr) m_flags = 5'd0;
         for (int i = 0; i < d; i++) begin
            w = q.pop_front();
            m_flags = m_flags | w[4:0];
         end
         n = 0;
         for (int p = 0; p < NP; p++) begin
            if (ret_en_in[p]) begin
               if (n < free) begin
                  q.push_back(ret_in[p*RW +: RW]);
                  n++;
               end else begin
                  m_ovf = 1'b1;
               end
            end
         end
         m_stall = (q.size() > DEPTH - NP);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [NP-1:0] en, input logic [RW-1:0] base);
      idle();
      ret_en_in = en;
      for (int p = 0; p < NP; p++) put(p, base + RW'(p));
      tick();
   endtask

   task automatic drain(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         idle();
         out0_rdy = 1'b1;
         out1_rdy = 1'b1;
         tick();
      end
   endtask

   initial begin
      // Reset
      idle();
      rst = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_v0", 32'(out0_valid), 32'd0);

      // Two non-adjacent ports compact into consecutive slots
      idle();
      ret_en_in = 6'b000101;
      put(0, 14'h0011);
      put(2, 14'h0022);
      tick();
      chk("tp1_out0", 32'(out0_data), 32'h0011);
      chk("tp1_out1", 32'(out1_data), 32'h0022);
      chk("tp1_cnt", 32'(cnt), 32'd2);

      idle(); out0_rdy = 1'b1; tick();
      chk("tp2_out0", 32'(out0_data), 32'h0022);
      chk("tp2_v1", 32'(out1_valid), 32'd0);
      idle(); out1_rdy = 1'b1; tick();
      chk("tp3_cnt", 32'(cnt), 32'd1);
      drain(1);

      // Stall threshold
      fill(6'h3f, 14'h0040);
      fill(6'h3f, 14'h0050);
      chk("tp4_cnt", 32'(cnt), 32'd12);
      chk("tp4_stall", 32'(fp_stall), 32'd1);
      drain(1);
      chk("tp4_stall10", 32'(fp_stall), 32'd0);
      drain(5);

      // Pointer wrap from a clean reset
      idle(); rst = 1'b0; tick(); rst = 1'b1;
      fill(6'h3f, 14'h0100);
      fill(6'h3f, 14'h0106);
      fill(6'h03, 14'h010c);
      drain(7);
      fill(6'h0f, 14'h0200);
      chk("wrap_out0", 32'(out0_data), 32'h0200);
      chk("wrap_out1", 32'(out1_data), 32'h0201);
      drain(1);
      chk("wrap_out0b", 32'(out0_data), 32'h0202);
      chk("wrap_out1b", 32'(out1_data), 32'h0203);
      drain(1);

      // Overflow with simultaneous full drain
      fill(6'h3f, 14'h0300);
      fill(6'h3f, 14'h0310);
      fill(6'h0f, 14'h0320);
      chk("ovf_full", 32'(cnt), 32'd16);
      idle();
      ret_en_in = 6'h3f;
      for (int p = 0; p < NP; p++) put(p, 14'h0340 + RW'(p));
      out0_rdy = 1'b1; out1_rdy = 1'b1;
      tick();
      chk("ovf_cnt", 32'(cnt), 32'd16);
      chk("ovf_err", 32'(ovf_err), 32'd1);
      drain(8);
      chk("ovf_sticky", 32'(ovf_err), 32'd1);

      // Exception flag accumulation and clear
      idle(); fflags_clr = 1'b1; tick();
      idle();
      ret_en_in = 6'b000111;
      put(0, 14'h0001); put(1, 14'h0010); put(2, 14'h0004);
      tick();
      idle(); out0_rdy = 1'b1; out1_rdy = 1'b1; tick();
      chk("flags_or", 32'(fflags), 32'h11);
      idle(); out0_rdy = 1'b1; fflags_clr = 1'b1; tick();
      chk("flags_clr", 32'(fflags), 32'h04);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         idle();
         ret_en_in  = 6'($urandom);
         for (int p = 0; p < NP; p++) put(p, 14'($urandom));
         out0_rdy   = 1'($urandom);
         out1_rdy   = 1'($urandom);
         fflags_clr = ($urandom_range(0, 7) == 0);
         tick();
      end

      // Reset mid-operation with handshakes requested
      fill(6'h3f, 14'h0500);
      idle(); rst = 1'b0; out0_rdy = 1'b1; out1_rdy = 1'b1; ret_en_in = 6'h3f; tick();
      rst = 1'b1;
      idle(); tick();
      chk("mrst_cnt", 32'(cnt), 32'd0);
      chk("mrst_ovf", 32'(ovf_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
